// File: rtl/rh_axi4_wr_slave_if.sv
// rh_axi4_wr_slave_if: AXI4 write-channel bundle (AW, W, B) for rh_axi4_wr_slave.
//   AW: AWVALID/AWREADY, AWADDR[AW], AWID[IW], AWLEN[8], AWSIZE[3], AWBURST[2],
//       AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER[UW]
//   W : WVALID/WREADY, WDATA[DW], WSTRB[DW/8], WLAST, WUSER[UW]
//   B : BVALID/BREADY, BID[IW], BRESP[2], BUSER[UW]
//   modport master drives requests, modport slave drives ready/response.
interface rh_axi4_wr_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int UW = 1
);
    logic          AWVALID;
    logic          AWREADY;
    logic [AW-1:0] AWADDR;
    logic [IW-1:0] AWID;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWLOCK;
    logic [3:0]    AWCACHE;
    logic [2:0]    AWPROT;
    logic [3:0]    AWQOS;
    logic [3:0]    AWREGION;
    logic [UW-1:0] AWUSER;

    logic            WVALID;
    logic            WREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic [UW-1:0]   WUSER;

    logic          BVALID;
    logic          BREADY;
    logic [IW-1:0] BID;
    logic [1:0]    BRESP;
    logic [UW-1:0] BUSER;

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE,
               AWPROT, AWQOS, AWREGION, AWUSER,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST, WUSER,
        input  WREADY,
        input  BVALID, BID, BRESP, BUSER,
        output BREADY
    );

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE,
               AWPROT, AWQOS, AWREGION, AWUSER,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST, WUSER,
        output WREADY,
        output BVALID, BID, BRESP, BUSER,
        input  BREADY
    );
endinterface

// File: rtl/rh_axi4_wr_slave.sv
// rh_axi4_wr_slave: single-outstanding AXI4 write slave feeding a simple memory write port.
//   ACLK, ARESET   : clock, asynchronous active-high reset
//   axi (slave)    : AXI4 AW/W/B channels
//   mem_we         : one-cycle write strobe, registered one edge after each accepted beat
//   mem_addr       : byte address of the beat
//   mem_wdata/wstrb: beat data and byte strobes
module rh_axi4_wr_slave #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int UW = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    rh_axi4_wr_slave_if.slave axi,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam logic [AW-1:0] ONE = 1;

    state_t        state, state_nxt;
    logic [IW-1:0] id_q, bid_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q, cnt_q;
    logic [2:0]    size_q;
    logic [1:0]    burst_q, bresp_q;
    logic          err_q, bvalid_q;

    logic          aw_hs, w_hs, b_hs, w_end, w_mis, aw_err;
    logic [AW-1:0] bytes, aligned, wmask, addr_nxt;
    logic          unused_ok;

    assign axi.AWREADY = (state == IDLE);
    assign axi.WREADY  = (state == DATA);
    assign axi.BVALID  = bvalid_q;
    assign axi.BID     = bid_q;
    assign axi.BRESP   = bresp_q;
    assign axi.BUSER   = '0;

    assign unused_ok = ^{axi.AWLOCK, axi.AWCACHE, axi.AWPROT, axi.AWQOS,
                         axi.AWREGION, axi.AWUSER, axi.WUSER};

    assign aw_hs = axi.AWVALID && (state == IDLE);
    assign w_hs  = axi.WVALID && (state == DATA);
    assign b_hs  = axi.BREADY && (state == RESP);

    // The burst ends on WLAST or on the final counted beat; disagreement is a protocol error.
    assign w_end = axi.WLAST || (cnt_q == len_q);
    assign w_mis = axi.WLAST != (cnt_q == len_q);

    assign aw_err = (axi.AWBURST == 2'b11) ||
                    ((32'd1 << axi.AWSIZE) > 32'(DW / 8)) ||
                    ((axi.AWBURST == 2'b10) && !(axi.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // Later beats are size-aligned; WRAP keeps the offset inside a (len+1)*size window.
    assign bytes    = ONE << size_q;
    assign aligned  = addr_q & ~(bytes - ONE);
    assign wmask    = ((AW'(len_q) + ONE) << size_q) - ONE;
    assign addr_nxt = (burst_q == 2'b00) ? addr_q :
                      (burst_q == 2'b10) ? ((addr_q & ~wmask) | ((aligned + bytes) & wmask)) :
                                           aligned + bytes;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (aw_hs)
            state_nxt = DATA;
        if (w_hs && w_end)
            state_nxt = RESP;
        if (b_hs)
            state_nxt = IDLE;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            // The write is issued from the flag as it stood before this beat, so a
            // WLAST mismatch on the ending beat still writes that beat.
            mem_we <= w_hs && !err_q;
            if (w_hs && !err_q) begin
                mem_addr  <= addr_q;
                mem_wdata <= axi.WDATA;
                mem_wstrb <= axi.WSTRB;
            end
            if (w_hs) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
            end
            if (w_hs && w_mis)
                err_q <= 1'b1;
            if (aw_hs) begin
                id_q    <= axi.AWID;
                addr_q  <= axi.AWADDR;
                len_q   <= axi.AWLEN;
                size_q  <= axi.AWSIZE;
                burst_q <= axi.AWBURST;
                cnt_q   <= '0;
                err_q   <= aw_err;
            end
            if (w_hs && w_end) begin
                bvalid_q <= 1'b1;
                bid_q    <= id_q;
                bresp_q  <= (err_q || w_mis) ? 2'b10 : 2'b00;
            end
            if (b_hs)
                bvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rh_axi4_wr_slave.sv
// tb_rh_axi4_wr_slave: randomized scoreboard bench for rh_axi4_wr_slave.
module tb_rh_axi4_wr_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    wr_t wq[$];
    b_t  bq[$];

    logic [3:0]  p_id;
    logic [31:0] p_addr[0:15];
    int          p_nb;
    int          p_last;
    bit          p_wr;
    logic [1:0]  p_resp;

    rh_axi4_wr_slave_if #(.AW(32), .DW(32), .IW(4), .UW(1)) axi ();

    rh_axi4_wr_slave #(.AW(32), .DW(32), .IW(4), .UW(1)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .axi       (axi),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares memory writes and B responses against the queued expectations.
    initial forever begin
        @(negedge ACLK);
        #1;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            chk("mem_we", mem_we, 1'b1);
            chk("mem_addr", mem_addr, wq[0].addr);
            chk("mem_wdata", mem_wdata, wq[0].data);
            chk("mem_wstrb", mem_wstrb, wq[0].strb);
            void'(wq.pop_front());
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
        end
        if (axi.BVALID) begin
            if (bq.size() == 0) begin
                chk("unexpected_bvalid", axi.BVALID, 1'b0);
            end else begin
                chk("bid", axi.BID, bq[0].id);
                chk("bresp", axi.BRESP, bq[0].resp);
                if (axi.BREADY)
                    void'(bq.pop_front());
            end
        end
    end

    // Reference plan for one burst, worked out from the burst rules directly.
    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int last_pos);
        int unsigned bytes, ws;
        logic [31:0] al, base;
        bit illegal;
        int e, n;
        bytes = 1 << size;
        al = addr / bytes * bytes;
        ws = (len + 1) * bytes;
        base = addr / ws * ws;
        for (int i = 0; i <= len; i++) begin
            if (i == 0 || burst == 0)
                p_addr[i] = addr;
            else if (burst == 2)
                p_addr[i] = base + ((al - base + i * bytes) % ws);
            else
                p_addr[i] = al + i * bytes;
        end
        illegal = (burst == 3) || (bytes > 4) || (burst == 2 && !(len inside {1, 3, 7, 15}));
        e = (last_pos < len) ? last_pos : len;
        p_nb = e + 1;
        p_last = last_pos;
        p_wr = !illegal;
        p_id = id;
        p_resp = (illegal || last_pos != len) ? 2'b10 : 2'b00;
        axi.AWVALID = 1'b1;
        axi.AWID = id;
        axi.AWADDR = addr;
        axi.AWLEN = 8'(len);
        axi.AWSIZE = 3'(size);
        axi.AWBURST = 2'(burst);
        n = 0;
        while (!axi.AWREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50)
            chk("aw_timeout", 1'b1, 1'b0);
        @(negedge ACLK);
        axi.AWVALID = 1'b0;
    endtask

    task automatic w_phase(input int max_beats);
        int n;
        for (int i = 0; i < p_nb && i < max_beats; i++) begin
            axi.WVALID = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge ACLK);
            axi.WVALID = 1'b1;
            axi.WDATA = $urandom;
            axi.WSTRB = 4'($urandom);
            axi.WLAST = (i == p_last);
            n = 0;
            while (!axi.WREADY && n < 50) begin
                @(negedge ACLK);
                n++;
            end
            if (n >= 50) begin
                chk("w_timeout", 1'b1, 1'b0);
                break;
            end
            if (p_wr)
                wq.push_back('{cyc + 1, p_addr[i], axi.WDATA, axi.WSTRB});
            if (i == p_nb - 1)
                bq.push_back('{p_id, p_resp});
            @(negedge ACLK);
        end
        axi.WVALID = 1'b0;
        axi.WLAST = 1'b0;
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!axi.BVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50)
            chk("b_timeout", 1'b1, 1'b0);
    endtask

    task automatic b_phase(input int hold);
        wait_bvalid();
        repeat (hold) @(negedge ACLK);
        axi.BREADY = 1'b1;
        @(negedge ACLK);
        axi.BREADY = 1'b0;
        chk("bvalid_drop", axi.BVALID, 1'b0);
        chk("awready_after_b", axi.AWREADY, 1'b1);
    endtask

    task automatic txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                       input int size, input int burst, input int last_pos, input int hold);
        aw_phase(id, addr, len, size, burst, last_pos);
        w_phase(16);
        b_phase(hold);
    endtask

    initial begin
        int r, burst, size, len, last_pos;
        logic [31:0] addr;
        axi.AWVALID = 0; axi.AWADDR = 0; axi.AWID = 0; axi.AWLEN = 0; axi.AWSIZE = 0;
        axi.AWBURST = 0; axi.AWLOCK = 0; axi.AWCACHE = 0; axi.AWPROT = 0; axi.AWQOS = 0;
        axi.AWREGION = 0; axi.AWUSER = 0; axi.WVALID = 0; axi.WDATA = 0; axi.WSTRB = 0;
        axi.WLAST = 0; axi.WUSER = 0; axi.BREADY = 0;

        #12;
        chk("rst_awready", axi.AWREADY, 1'b1);
        chk("rst_wready", axi.WREADY, 1'b0);
        chk("rst_bvalid", axi.BVALID, 1'b0);
        chk("rst_bid", axi.BID, 4'h0);
        chk("rst_bresp", axi.BRESP, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // W beat offered before any AW must be stalled.
        axi.WVALID = 1'b1;
        axi.WDATA = 32'hdead_beef;
        axi.WSTRB = 4'hf;
        repeat (2) begin
            chk("w_stall_idle", axi.WREADY, 1'b0);
            @(negedge ACLK);
        end
        txn(4'd5, 32'h100, 3, 2, 1, 3, 0);
        txn(4'd6, 32'h10c, 3, 2, 2, 3, 1);
        txn(4'd7, 32'h200, 3, 2, 1, 1, 0);
        txn(4'd8, 32'h300, 1, 2, 3, 1, 0);
        txn(4'd9, 32'h400, 1, 3, 1, 1, 2);
        txn(4'd1, 32'h503, 2, 0, 0, 2, 0);

        // Backpressure: B held for 5 cycles while a second AW waits.
        aw_phase(4'd3, 32'h600, 1, 2, 1, 1);
        w_phase(16);
        wait_bvalid();
        axi.AWVALID = 1'b1;
        axi.AWID = 4'd4;
        axi.AWADDR = 32'h700;
        axi.AWLEN = 8'd0;
        axi.AWSIZE = 3'd2;
        axi.AWBURST = 2'b01;
        repeat (5) begin
            chk("aw_stall_resp", axi.AWREADY, 1'b0);
            chk("bvalid_hold", axi.BVALID, 1'b1);
            @(negedge ACLK);
        end
        axi.BREADY = 1'b1;
        chk("aw_stall_bhs", axi.AWREADY, 1'b0);
        @(negedge ACLK);
        axi.BREADY = 1'b0;
        chk("bubble_awready", axi.AWREADY, 1'b1);
        chk("bubble_bvalid", axi.BVALID, 1'b0);
        aw_phase(4'd4, 32'h700, 0, 2, 1, 0);
        w_phase(16);
        b_phase(0);

        // Reset after the first beat of a 4-beat burst.
        aw_phase(4'd2, 32'h800, 3, 2, 1, 3);
        w_phase(1);
        @(negedge ACLK);
        axi.WVALID = 1'b1;
        #2;
        ARESET = 1'b1;
        #1;
        chk("mrst_awready", axi.AWREADY, 1'b1);
        chk("mrst_wready", axi.WREADY, 1'b0);
        chk("mrst_bvalid", axi.BVALID, 1'b0);
        chk("mrst_mem_we", mem_we, 1'b0);
        chk("mrst_mem_addr", mem_addr, 32'h0);
        chk("mrst_mem_wdata", mem_wdata, 32'h0);
        chk("mrst_mem_wstrb", mem_wstrb, 4'h0);
        chk("mrst_bid", axi.BID, 4'h0);
        chk("mrst_bresp", axi.BRESP, 2'b00);
        chk("mrst_pending_wr", wq.size(), 0);
        repeat (2) @(negedge ACLK);
        axi.WVALID = 1'b0;
        ARESET = 1'b0;
        txn(4'd11, 32'h900, 3, 2, 1, 3, 0);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            burst = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            size = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            if (burst == 2) begin
                r = $urandom_range(0, 8);
                len = (r == 8) ? 2 : (2 << (r % 4)) - 1;
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = $urandom;
            if (burst == 0)
                addr = addr & ~((32'd1 << size) - 32'd1);
            last_pos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 1) : len;
            txn(4'($urandom), addr, len, size, burst, last_pos, $urandom_range(0, 3));
        end

        repeat (3) @(negedge ACLK);
        chk("wq_drained", wq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end
endmodule
